// File: rtl/sc_downspeedticker.sv
// Programmable periodic tick generator: a down-counter reloads from BASE >> level
// and emits a one-cycle tick at terminal count; level is stepped by active-low strobes.
module sc_downspeedticker #(
  parameter int unsigned                           DOWNSPEEDTICKER_DATAWIDTH = 23,
  parameter logic [DOWNSPEEDTICKER_DATAWIDTH-1:0]  DOWNSPEEDTICKER_BASE      = 23'd5000000,
  parameter int unsigned                           DOWNSPEEDTICKER_MAXLEVEL  = 7
) (
  input  logic                                 SC_downSPEEDTICKER_CLOCK_50,
  input  logic                                 SC_downSPEEDTICKER_RESET_InHigh,
  input  logic                                 SC_downSPEEDTICKER_start_InLow,
  input  logic                                 SC_downSPEEDTICKER_stop_InLow,
  input  logic                                 SC_downSPEEDTICKER_speedup_InLow,
  input  logic                                 SC_downSPEEDTICKER_speeddown_InLow,
  output logic                                 SC_downSPEEDTICKER_tick_Out,
  output logic                                 SC_downSPEEDTICKER_running_Out,
  output logic [2:0]                           SC_downSPEEDTICKER_level_OutBUS,
  output logic [DOWNSPEEDTICKER_DATAWIDTH-1:0] SC_downSPEEDTICKER_data_OutBUS
);

  localparam int unsigned DW = DOWNSPEEDTICKER_DATAWIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [2:0]      r_level, w_level_next;
  logic [DW-1:0]   r_count, w_count_next;
  logic            r_tick,  w_tick_next;
  logic [DW-1:0]   w_reload;

  logic w_up, w_down;
  assign w_up   = ~SC_downSPEEDTICKER_speedup_InLow;
  assign w_down = ~SC_downSPEEDTICKER_speeddown_InLow;

  // Each level step halves the period; uses the registered level, so IDLE tracks one cycle late.
  assign w_reload = DOWNSPEEDTICKER_BASE >> r_level;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_level_next = r_level;
    if (w_up && !w_down && (r_level != 3'(DOWNSPEEDTICKER_MAXLEVEL)))
      w_level_next = r_level + 3'd1;
    else if (w_down && !w_up && (r_level != 3'd0))
      w_level_next = r_level - 3'd1;
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_next = w_reload;
        if (!SC_downSPEEDTICKER_start_InLow && SC_downSPEEDTICKER_stop_InLow)
          w_state_next = RUN;
      end
      RUN: begin
        if (!SC_downSPEEDTICKER_stop_InLow) begin
          w_state_next = IDLE;
          w_count_next = w_reload;
        end else if (r_count == '0) begin
          // Reload at terminal count; a level change mid-countdown lands here, not earlier.
          w_count_next = w_reload;
          w_tick_next  = 1'b1;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge SC_downSPEEDTICKER_CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (SC_downSPEEDTICKER_RESET_InHigh) begin
      r_state <= IDLE;
      r_level <= 3'd0;
      r_count <= DOWNSPEEDTICKER_BASE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_level <= w_level_next;
      r_count <= w_count_next;
      r_tick  <= w_tick_next;
    end
  end

  assign SC_downSPEEDTICKER_tick_Out     = r_tick;
  assign SC_downSPEEDTICKER_running_Out  = (r_state == RUN);
  assign SC_downSPEEDTICKER_level_OutBUS = r_level;
  assign SC_downSPEEDTICKER_data_OutBUS  = r_count;

endmodule

// File: tb/tb_sc_downspeedticker.sv
// Self-checking bench for sc_downspeedticker: directed scenarios plus random strobes,
// compared every cycle against a cycle-level behavioural model (BASE = 10, MAXLEVEL = 3).
module tb_sc_downspeedticker;

  localparam int DW       = 23;
  localparam int BASE     = 10;
  localparam int MAXLEVEL = 3;

  logic          clk = 1'b0;
  logic          i_rst, i_start_n, i_stop_n, i_up_n, i_dn_n;
  logic          o_tick, o_running;
  logic [2:0]    o_level;
  logic [DW-1:0] o_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_level;
  bit m_run;
  int m_count;
  bit m_tick;

  sc_downspeedticker #(
    .DOWNSPEEDTICKER_DATAWIDTH (DW),
    .DOWNSPEEDTICKER_BASE      (23'(BASE)),
    .DOWNSPEEDTICKER_MAXLEVEL  (MAXLEVEL)
  ) dut (
    .SC_downSPEEDTICKER_CLOCK_50        (clk),
    .SC_downSPEEDTICKER_RESET_InHigh    (i_rst),
    .SC_downSPEEDTICKER_start_InLow     (i_start_n),
    .SC_downSPEEDTICKER_stop_InLow      (i_stop_n),
    .SC_downSPEEDTICKER_speedup_InLow   (i_up_n),
    .SC_downSPEEDTICKER_speeddown_InLow (i_dn_n),
    .SC_downSPEEDTICKER_tick_Out        (o_tick),
    .SC_downSPEEDTICKER_running_Out     (o_running),
    .SC_downSPEEDTICKER_level_OutBUS    (o_level),
    .SC_downSPEEDTICKER_data_OutBUS     (o_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
  endtask

  // Period rule: the reload halves per level, using the level in force before the edge.
  function automatic int period_reload(input int level);
    return BASE / (2 ** level);
  endfunction

  task automatic model_step(input bit rst, input bit st_n, input bit sp_n, input bit up_n, input bit dn_n);
    int r;
    r = period_reload(m_level);
    if (rst) begin
      m_level = 0; m_run = 0; m_count = BASE; m_tick = 0;
      return;
    end
    if (!up_n && dn_n)      m_level = (m_level < MAXLEVEL) ? m_level + 1 : MAXLEVEL;
    else if (up_n && !dn_n) m_level = (m_level > 0) ? m_level - 1 : 0;
    m_tick = 0;
    if (!m_run) begin
      m_count = r;
      m_run   = (!st_n && sp_n);
    end else if (!sp_n) begin
      m_run   = 0;
      m_count = r;
    end else if (m_count == 0) begin
      m_count = r;
      m_tick  = 1;
    end else begin
      m_count = m_count - 1;
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare every output against the model.
  task automatic step(input bit rst, input bit st_n, input bit sp_n, input bit up_n, input bit dn_n);
    i_rst = rst; i_start_n = st_n; i_stop_n = sp_n; i_up_n = up_n; i_dn_n = dn_n;
    @(posedge clk);
    model_step(rst, st_n, sp_n, up_n, dn_n);
    #1;
    check("tick",    32'(o_tick),    32'(m_tick));
    check("running", 32'(o_running), 32'(m_run));
    check("level",   32'(o_level),   32'(m_level));
    check("data",    32'(o_data),    32'(m_count));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, 1);
  endtask

  // Bounded wait until the model countdown reaches the target value.
  task automatic run_until_count(input int target);
    int guard;
    guard = 0;
    while (m_count != target && guard < 64) begin
      step(0, 1, 1, 1, 1);
      guard++;
    end
    check("wait_count", 32'(m_count), 32'(target));
  endtask

  initial begin
    int tick_edges[$];
    i_rst = 1; i_start_n = 1; i_stop_n = 1; i_up_n = 1; i_dn_n = 1;

    // Reset for two cycles, then hold with no strobes.
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    check("rst_level", 32'(o_level), 0);
    check("rst_data",  32'(o_data), 10);
    check("rst_tick",  32'(o_tick), 0);
    check("rst_run",   32'(o_running), 0);
    idle_cycles(6);
    check("idle_data", 32'(o_data), 10);

    // Start at edge 0: ticks after edges 11, 22, 33.
    step(0, 0, 1, 1, 1);
    check("start_run",  32'(o_running), 1);
    check("start_data", 32'(o_data), 10);
    for (int e = 1; e <= 33; e++) begin
      step(0, 1, 1, 1, 1);
      if (o_tick) tick_edges.push_back(e);
      if (e == 10) check("cnt_zero", 32'(o_data), 0);
    end
    check("tick_count", 32'(tick_edges.size()), 3);
    for (int i = 0; i < tick_edges.size() && i < 3; i++)
      check("tick_edge", 32'(tick_edges[i]), 32'(11 * (i + 1)));

    // Speedup held for four cycles during RUN: 1, 2, 3, 3; countdown in flight finishes at R=10.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 1);
      check("speedup_lvl", 32'(o_level), 32'((i < 3) ? i + 1 : 3));
    end
    run_until_count(0);
    step(0, 1, 1, 1, 1);
    check("tick_after_lvl", 32'(o_tick), 1);
    check("reload_lvl3",    32'(o_data), 1);
    idle_cycles(8);

    // Back to level 0 via reset, then saturation and simultaneous strobes.
    step(1, 1, 1, 1, 1);
    step(0, 1, 1, 1, 0);
    check("down_sat", 32'(o_level), 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    check("both_hold", 32'(o_level), 1);

    // Start and stop together in IDLE: stays idle.
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1);
    check("ss_run",  32'(o_running), 0);
    check("ss_data", 32'(o_data), 10);
    check("ss_tick", 32'(o_tick), 0);

    // Stop in RUN exactly when count is 0: no tick, count reloads.
    step(0, 0, 1, 1, 1);
    run_until_count(0);
    step(0, 1, 0, 1, 1);
    check("stop0_tick", 32'(o_tick), 0);
    check("stop0_data", 32'(o_data), 10);
    check("stop0_run",  32'(o_running), 0);

    // Reset mid-RUN at level 2 with count 1: pending tick suppressed.
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    check("lvl2_reload", 32'(o_data), 2);
    run_until_count(1);
    step(1, 1, 1, 1, 1);
    check("midrst_run",   32'(o_running), 0);
    check("midrst_level", 32'(o_level), 0);
    check("midrst_data",  32'(o_data), 10);
    check("midrst_tick",  32'(o_tick), 0);
    step(0, 1, 1, 1, 1);
    check("midrst_notick", 32'(o_tick), 0);

    // Randomised strobes against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_st, r_sp, r_up, r_dn;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 7)  != 0);
      r_sp  = ($urandom_range(0, 39) != 0);
      r_up  = ($urandom_range(0, 9)  != 0);
      r_dn  = ($urandom_range(0, 9)  != 0);
      step(r_rst, r_st, r_sp, r_up, r_dn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
